// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX write port; one arbitration cycle per grant, 1-cycle write latency.
// Backpressure: the granted requester's ready drops while the downstream ring has no free slots (credits == 0).
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int WORD_SIZE    = 8,
    parameter int TX_RING_SIZE = 16,
    parameter int MAX_BURST    = 4,
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CW  = $clog2(TX_RING_SIZE + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*WORD_SIZE-1:0]   req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           tx_done,
    output logic [WORD_SIZE-1:0]           data_in,
    output logic                           write_nic,
    output logic [IDW-1:0]                 grant_id,
    output logic                           busy,
    output logic [CW-1:0]                  credits
);

    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state_q;
    logic [IDW-1:0]        rr_ptr_q;
    logic [IDW-1:0]        grant_q;
    logic [BW-1:0]         burst_cnt_q;
    logic [CW-1:0]         credits_q;
    logic                  write_nic_q;
    logic [WORD_SIZE-1:0]  data_q;

    logic [IDW-1:0]        pick_d;
    logic [IDW-1:0]        rr_ptr_d;
    logic                  any_vld;
    logic                  has_credit;
    logic                  credit_full;
    logic                  xfer;
    logic                  burst_end;

    // Walk offsets high-to-low so the requester closest to rr_ptr wins.
    always_comb begin
        int idx;
        idx     = 0;
        pick_d  = rr_ptr_q;
        any_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                pick_d  = IDW'(idx);
                any_vld = 1'b1;
            end
        end
    end

    assign has_credit  = (credits_q != '0);
    assign credit_full = (credits_q == CW'(TX_RING_SIZE));
    assign xfer        = (state_q == BURST) && req_valid[grant_q] && has_credit;
    assign burst_end   = xfer && (req_last[grant_q] || (burst_cnt_q == BW'(MAX_BURST - 1)));
    assign rr_ptr_d    = (int'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + 1'b1;

    always_comb begin
        req_ready = '0;
        if (state_q == BURST) begin
            req_ready[grant_q] = has_credit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            burst_cnt_q <= '0;
            credits_q   <= CW'(TX_RING_SIZE);
            write_nic_q <= 1'b0;
            data_q      <= '0;
        end else begin
            write_nic_q <= xfer;
            if (xfer) begin
                data_q <= req_data[grant_q*WORD_SIZE +: WORD_SIZE];
            end
            // A slot freed in the same cycle as one consumed cancels out; a release at full is spurious.
            if (xfer && !tx_done) begin
                credits_q <= credits_q - 1'b1;
            end else if (!xfer && tx_done && !credit_full) begin
                credits_q <= credits_q + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (any_vld) begin
                        grant_q     <= pick_d;
                        burst_cnt_q <= '0;
                        state_q     <= BURST;
                    end
                end
                BURST: begin
                    if (xfer) begin
                        burst_cnt_q <= burst_cnt_q + 1'b1;
                        if (burst_end) begin
                            state_q  <= IDLE;
                            rr_ptr_q <= rr_ptr_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = (state_q == BURST);
    assign grant_id  = grant_q;
    assign credits   = credits_q;
    assign write_nic = write_nic_q;
    assign data_in   = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle table for the basic grant/reset path, then
// scoreboard-driven requester queues for round-robin, burst cap, credit and reset corners.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_done;
    logic [7:0]  data_in;
    logic        write_nic;
    logic [1:0]  grant_id;
    logic        busy;
    logic [4:0]  credits;

    uart_tx_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_done   (tx_done),
        .data_in   (data_in),
        .write_nic (write_nic),
        .grant_id  (grant_id),
        .busy      (busy),
        .credits   (credits)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic [31:0] dat;
        logic [3:0]  lst;
        logic        td;
        logic [3:0]  rdy;
        logic        busy;
        logic [1:0]  gid;
        logic        wr;
        logic [7:0]  din;
        logic [4:0]  cred;
    } vec_t;

    vec_t vt[$];

    task automatic addv(input logic r, input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                        input logic t, input logic [3:0] rd, input logic b, input logic [1:0] g,
                        input logic w, input logic [7:0] di, input logic [4:0] c);
        vec_t e;
        e.rst = r; e.vld = v; e.dat = d; e.lst = l; e.td = t;
        e.rdy = rd; e.busy = b; e.gid = g; e.wr = w; e.din = di; e.cred = c;
        vt.push_back(e);
    endtask

    // Requester model and scoreboard
    logic [8:0]  rq [4][$];
    logic [7:0]  sb[$];
    int          grant_log[$];
    int          xfer_cycles[$];
    logic [3:0]  en;
    logic        td_drv;
    logic        mon_en;
    logic [3:0]  xfer_obs;
    int          cred_m;
    int          cred_nx;
    int          cyc;

    task automatic drive();
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int i = 0; i < 4; i++) begin
            if (en[i] && rq[i].size() != 0) begin
                req_valid[i]         = 1'b1;
                req_data[i*8 +: 8]   = rq[i][0][7:0];
                req_last[i]          = rq[i][0][8];
            end
        end
        tx_done = td_drv;
    endtask

    task automatic monitor();
        logic [7:0] e;
        chk("credits", credits, cred_m);
        chk("ready_onehot", ($countones(req_ready) <= 1), 1);
        if (!busy) chk("ready_idle", req_ready, 0);
        if (write_nic) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("data_in", data_in, e);
            end
        end
        xfer_obs = rst ? 4'b0 : (req_valid & req_ready);
        for (int i = 0; i < 4; i++) begin
            if (xfer_obs[i] && rq[i].size() != 0) begin
                sb.push_back(rq[i][0][7:0]);
                grant_log.push_back(i);
                xfer_cycles.push_back(cyc);
                chk("grant_id", grant_id, i);
            end
        end
        if (rst) cred_nx = 16;
        else if ((|xfer_obs) && tx_done) cred_nx = cred_m;
        else if (|xfer_obs) cred_nx = cred_m - 1;
        else if (tx_done && cred_m < 16) cred_nx = cred_m + 1;
        else cred_nx = cred_m;
    endtask

    task automatic cycle();
        @(negedge clk);
        xfer_obs = '0;
        cred_nx  = cred_m;
        if (mon_en) monitor();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (xfer_obs[i] && rq[i].size() != 0) void'(rq[i].pop_front());
        end
        cred_m = cred_nx;
        cyc++;
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic clear();
        grant_log.delete();
        xfer_cycles.delete();
        for (int i = 0; i < 4; i++) rq[i].delete();
        en = '0;
        td_drv = 1'b0;
        drive();
    endtask

    function automatic bit pending();
        bit p;
        p = (sb.size() != 0);
        for (int i = 0; i < 4; i++) if (rq[i].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic run_until(input string nm, input int maxc);
        int n;
        n = 0;
        while (pending() && n < maxc) begin
            cycle();
            n++;
        end
        chk(nm, (n < maxc), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int rr_exp[6];
        int cap_gap[5];
        int n;
        rr_exp  = '{0, 1, 3, 0, 1, 3};
        cap_gap = '{1, 1, 1, 2, 1};

        rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_done = 1'b0;
        mon_en = 1'b0; en = '0; td_drv = 1'b0; cred_m = 16; cyc = 0;
        @(posedge clk);
        #1;

        //    rst  vld      dat           lst      td   | rdy      busy gid  wr   din    cred
        addv(0, 4'b0001, 32'h0000_00A1, 4'b0000, 0,  4'b0000, 0, 2'd0, 0, 8'h00, 5'd16);
        addv(0, 4'b0001, 32'h0000_00A1, 4'b0000, 0,  4'b0001, 1, 2'd0, 0, 8'h00, 5'd16);
        addv(0, 4'b0001, 32'h0000_00A2, 4'b0000, 0,  4'b0001, 1, 2'd0, 1, 8'hA1, 5'd15);
        addv(0, 4'b0001, 32'h0000_00A3, 4'b0001, 0,  4'b0001, 1, 2'd0, 1, 8'hA2, 5'd14);
        addv(0, 4'b0000, 32'h0000_0000, 4'b0000, 0,  4'b0000, 0, 2'd0, 1, 8'hA3, 5'd13);
        addv(0, 4'b0000, 32'h0000_0000, 4'b0000, 0,  4'b0000, 0, 2'd0, 0, 8'hA3, 5'd13);
        addv(0, 4'b1111, 32'h0000_0000, 4'b0000, 0,  4'b0000, 0, 2'd0, 0, 8'hA3, 5'd13);
        addv(0, 4'b0000, 32'h0000_0000, 4'b0000, 0,  4'b0010, 1, 2'd1, 0, 8'hA3, 5'd13);
        addv(0, 4'b0001, 32'h0000_0077, 4'b0001, 0,  4'b0010, 1, 2'd1, 0, 8'hA3, 5'd13);
        addv(0, 4'b0010, 32'h0000_5B77, 4'b0011, 0,  4'b0010, 1, 2'd1, 0, 8'hA3, 5'd13);
        addv(0, 4'b0000, 32'h0000_0000, 4'b0000, 0,  4'b0000, 0, 2'd1, 1, 8'h5B, 5'd12);
        addv(1, 4'b1111, 32'h0000_0000, 4'b0000, 1,  4'b0000, 0, 2'd1, 0, 8'h5B, 5'd12);
        addv(0, 4'b0000, 32'h0000_0000, 4'b0000, 1,  4'b0000, 0, 2'd0, 0, 8'h00, 5'd16);
        addv(0, 4'b0000, 32'h0000_0000, 4'b0000, 0,  4'b0000, 0, 2'd0, 0, 8'h00, 5'd16);

        for (int k = 0; k < vt.size(); k++) begin
            rst = vt[k].rst; req_valid = vt[k].vld; req_data = vt[k].dat;
            req_last = vt[k].lst; tx_done = vt[k].td;
            @(negedge clk);
            chk($sformatf("v%0d req_ready", k), req_ready, vt[k].rdy);
            chk($sformatf("v%0d busy", k), busy, vt[k].busy);
            chk($sformatf("v%0d grant_id", k), grant_id, vt[k].gid);
            chk($sformatf("v%0d write_nic", k), write_nic, vt[k].wr);
            chk($sformatf("v%0d data_in", k), data_in, vt[k].din);
            chk($sformatf("v%0d credits", k), credits, vt[k].cred);
            @(posedge clk);
            #1;
        end

        // Round robin over requesters 0,1,3 with single-word messages
        mon_en = 1'b1; rst = 1'b0;
        clear(); do_reset(); clear();
        for (int r = 0; r < 2; r++) begin
            rq[0].push_back({1'b1, 8'h10 + 8'(r)});
            rq[1].push_back({1'b1, 8'h20 + 8'(r)});
            rq[3].push_back({1'b1, 8'h30 + 8'(r)});
        end
        en = 4'b1011; drive();
        run_until("rr_drain", 60);
        chk("rr_count", grant_log.size(), 6);
        if (grant_log.size() == 6) begin
            for (int j = 0; j < 6; j++) chk($sformatf("rr_order%0d", j), grant_log[j], rr_exp[j]);
            for (int j = 1; j < 6; j++) chk($sformatf("rr_gap%0d", j), xfer_cycles[j] - xfer_cycles[j-1], 2);
        end

        // Burst cap: six words, no last, from requester 2
        clear(); do_reset(); clear();
        for (int k = 0; k < 6; k++) rq[2].push_back({1'b0, 8'h40 + 8'(k)});
        en = 4'b0100; drive();
        run_until("cap_drain", 40);
        chk("cap_count", grant_log.size(), 6);
        if (xfer_cycles.size() == 6) begin
            for (int j = 1; j < 6; j++) chk($sformatf("cap_gap%0d", j), xfer_cycles[j] - xfer_cycles[j-1], cap_gap[j-1]);
            for (int j = 0; j < 6; j++) chk($sformatf("cap_gid%0d", j), grant_log[j], 2);
        end
        chk("cap_still_busy", busy, 1);

        // Credit stall: ring fills after 16 writes, one tx_done releases exactly one more
        clear(); do_reset(); clear();
        for (int k = 0; k < 20; k++) rq[0].push_back({1'b0, 8'h60 + 8'(k)});
        en = 4'b0001; drive();
        for (int k = 0; k < 45; k++) cycle();
        chk("stall_xfers", xfer_cycles.size(), 16);
        chk("stall_credits", credits, 0);
        chk("stall_ready", req_ready, 0);
        chk("stall_busy", busy, 1);
        td_drv = 1'b1; drive();
        cycle();
        chk("release_credits", credits, 1);
        td_drv = 1'b0; drive();
        for (int k = 0; k < 8; k++) cycle();
        chk("release_xfers", xfer_cycles.size(), 17);
        chk("release_credits_end", credits, 0);

        // tx_done held: saturates at full and cancels each transfer
        clear(); do_reset(); clear();
        rq[1].push_back({1'b0, 8'h51});
        rq[1].push_back({1'b0, 8'h52});
        rq[1].push_back({1'b1, 8'h53});
        en = 4'b0010; td_drv = 1'b1; drive();
        run_until("corner_drain", 20);
        td_drv = 1'b0; drive();
        cycle();
        chk("corner_xfers", xfer_cycles.size(), 3);
        chk("corner_credits", credits, 16);

        // Reset mid-burst, with rr_ptr moved away from 0 beforehand
        clear(); do_reset(); clear();
        rq[0].push_back({1'b1, 8'h80});
        en = 4'b0001; drive();
        run_until("mid_pre_drain", 10);
        grant_log.delete(); xfer_cycles.delete();
        for (int k = 0; k < 4; k++) rq[3].push_back({1'b0, 8'h90 + 8'(k)});
        en = 4'b1000; drive();
        n = 0;
        while (xfer_cycles.size() < 2 && n < 10) begin
            cycle();
            n++;
        end
        chk("mid_two_words", xfer_cycles.size(), 2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_credits", credits, 16);
        chk("mid_rst_write_nic", write_nic, 0);
        chk("mid_rst_sb_empty", sb.size(), 0);
        grant_log.delete();
        rq[0].push_back({1'b1, 8'hA0});
        en = 4'b1001; drive();
        n = 0;
        while (grant_log.size() < 1 && n < 10) begin
            cycle();
            n++;
        end
        chk("mid_regrant_seen", grant_log.size(), 1);
        if (grant_log.size() >= 1) chk("mid_rr_ptr_reset", grant_log[0], 0);
        run_until("mid_post_drain", 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the UART transmit write port.
REQ-002 Parameter WORD_SIZE, default 8, data word width.
REQ-003 Parameter TX_RING_SIZE, default 16, depth of the downstream controller transmit ring; this is the credit ceiling.
REQ-004 Parameter MAX_BURST, default 4, maximum words per grant.
REQ-005 Reset is rst, synchronous, active-high; the clock is clk.
REQ-006 Ports, as name, direction, width, meaning:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- req_valid, in, NUM_REQ, per-requester word valid.
- req_data, in, NUM_REQ*WORD_SIZE, per-requester word; requester i uses bits [i*WORD_SIZE +: WORD_SIZE].
- req_last, in, NUM_REQ, per-requester last-word-of-message flag.
- req_ready, out, NUM_REQ, per-requester accept.
- tx_done, in, 1, one-cycle pulse for each word the controller hands to its transmitter (ring slot freed).
- data_in, out, WORD_SIZE, word to the controller.
- write_nic, out, 1, one-cycle write strobe to the controller.
- grant_id, out, clog2(NUM_REQ), current or last granted requester.
- busy, out, 1, high while in BURST.
- credits, out, clog2(TX_RING_SIZE+1), free ring slots.

Function
REQ-007 The FSM shall have two states, IDLE and BURST.
REQ-008 In IDLE with any req_valid high, the block shall pick the first requester with valid high, searching from rr_ptr upward modulo NUM_REQ, register it in grant_id, and enter BURST on the next cycle.
REQ-009 In IDLE, req_ready shall be all zero and no word shall transfer, so every grant is preceded by one arbitration cycle.
REQ-010 In BURST, req_ready[grant_id] shall equal (credits != 0), and all other req_ready bits shall be 0.
REQ-011 A transfer shall occur on a cycle where req_valid[g] and req_ready[g] are both high, with g = grant_id.
REQ-012 On a transfer, data_in shall take req_data[g] and write_nic shall be 1 on the next cycle (1-cycle latency); otherwise write_nic shall be 0 and data_in shall hold its value.
REQ-013 A burst counter shall clear on entry to BURST and increment on each transfer.
REQ-014 BURST shall end, returning to IDLE, on a transfer that has req_last[g] set or that is the MAX_BURST-th transfer of the grant.
REQ-015 When BURST ends, rr_ptr shall become (g+1) mod NUM_REQ.
REQ-016 A requester deasserting valid mid-burst shall keep the grant; the bubble is allowed and no other requester is served.
REQ-017 Credits shall update as follows: minus 1 on a transfer, plus 1 on tx_done, unchanged when both occur in the same cycle.
REQ-018 At credits == 0, no transfer shall occur; a same-cycle tx_done shall raise credits to 1, usable on the next cycle.
REQ-019 tx_done at credits == TX_RING_SIZE shall be ignored (saturate); credits shall never exceed TX_RING_SIZE or go below 0.
REQ-020 busy shall be 1 exactly when the state is BURST.
REQ-021 req_data and req_last of non-granted requesters shall have no effect.

Reset
REQ-022 On rst, the block shall set: state IDLE, rr_ptr 0, grant_id 0, burst counter 0, credits TX_RING_SIZE, write_nic 0, data_in 0, req_ready 0, busy 0.
REQ-023 rst mid-burst shall take effect on the next edge, dropping the partial burst, and shall not produce a write_nic pulse on the cycle after reset.
REQ-024 rst shall override all simultaneous valid and tx_done inputs.

Verification
REQ-025 Scenario (single requester): after reset, req_valid=4'b0001 with 3 words A1,A2,A3 and last on A3 -> grant_id=0, write_nic pulses carry A1,A2,A3, then IDLE, rr_ptr=1, credits=13.
REQ-026 Scenario (round-robin): req_valid=4'b1011 held, single-word messages each with last -> grant order 0,1,3,0,1,3, with one idle cycle between grants.
REQ-027 Scenario (burst cap): requester 2 sends 6 words with no last -> 4 words, then return to IDLE, re-grant to 2 (the only valid requester), 2 more words.
REQ-028 Scenario (credit stall): 16 writes with no tx_done -> credits=0 and req_ready low; one tx_done pulse -> credits=1 and exactly one further transfer.
REQ-029 Scenario (credit corner cases): a transfer and tx_done in the same cycle -> credits unchanged; tx_done at credits=16 -> credits stays 16.
REQ-030 Scenario (reset mid-burst): rst asserted after the 2nd word of a 4-word burst -> next cycle busy=0, credits=16, write_nic=0, rr_ptr=0.
